// File: rtl/cc_line_fill_unit.sv
// cc_line_fill_unit: collects one 8-beat WRAP burst per outstanding miss,
// rotates it back into line order and issues a single 512-bit SRAM line write.
module cc_line_fill_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  mem_rdata_i,
    input  logic         mem_rlast_i,
    input  logic         mem_rvalid_i,
    input  logic         mem_rready_i,
    input  logic         miss_addr_fifo_empty_i,
    input  logic [31:0]  miss_addr_fifo_rdata_i,
    output logic         miss_addr_fifo_rden_o,
    output logic         wren_o,
    output logic [8:0]   waddr_o,
    output logic [17:0]  wdata_tag_o,
    output logic [511:0] wdata_data_o,
    output logic         fill_err_o
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nxt;
    logic [2:0]        count;      // beats accepted so far in this burst
    logic [2:0]        start;      // critical word the burst wraps from
    logic [16:0]       tag;
    logic [8:0]        index;
    logic [7:0][63:0]  line, line_nxt;
    logic              beat;       // handshaken beat on the R channel
    logic              take;       // beat belongs to the current miss
    logic              last_beat;  // beat 7 of the current miss
    logic [2:0]        wptr;
    logic [2:0]        kpos;       // burst position of the current beat

    // Low address bits are below beat granularity and never matter.
    logic unused_low_bits;
    assign unused_low_bits = ^miss_addr_fifo_rdata_i[2:0];

    assign beat = mem_rvalid_i & mem_rready_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, pop strobe, and which beats are captured.
    always_comb begin
        state_nxt             = state;
        miss_addr_fifo_rden_o = 1'b0;
        take                  = 1'b0;
        last_beat             = 1'b0;
        case (state)
            IDLE: begin
                if (!miss_addr_fifo_empty_i) begin
                    miss_addr_fifo_rden_o = 1'b1;
                    take                  = beat;
                    state_nxt             = FILL;
                end
            end
            FILL: begin
                take = beat;
                if (beat && count == 3'd7) begin
                    last_beat = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word slot for the current beat; in IDLE the start word comes straight
    // from the FIFO head so a beat 0 arriving with the pop is not lost.
    always_comb begin
        kpos     = (state == IDLE) ? 3'd0 : count;
        wptr     = (state == IDLE) ? miss_addr_fifo_rdata_i[5:3] : start + count;
        line_nxt = line;
        if (take) line_nxt[wptr] = mem_rdata_i;
    end

    // Assembly buffer, miss context, beat counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line       <= '0;
            count      <= 3'd0;
            start      <= 3'd0;
            tag        <= 17'd0;
            index      <= 9'd0;
            fill_err_o <= 1'b0;
        end else begin
            line <= line_nxt;
            if (miss_addr_fifo_rden_o) begin
                tag   <= miss_addr_fifo_rdata_i[31:15];
                index <= miss_addr_fifo_rdata_i[14:6];
                start <= miss_addr_fifo_rdata_i[5:3];
                count <= take ? 3'd1 : 3'd0;
            end else if (take) begin
                count <= count + 3'd1;  // wraps to 0 after beat 7
            end
            // Stray beat with no miss outstanding, or rlast in the wrong place.
            if (beat && state == IDLE && miss_addr_fifo_empty_i)
                fill_err_o <= 1'b1;
            if (take && (mem_rlast_i != (kpos == 3'd7)))
                fill_err_o <= 1'b1;
        end
    end

    // Output write register; separate from the assembly buffer so the next
    // burst can assemble while this line is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_o       <= 1'b0;
            waddr_o      <= 9'd0;
            wdata_tag_o  <= 18'd0;
            wdata_data_o <= '0;
        end else begin
            wren_o <= last_beat;
            if (last_beat) begin
                waddr_o      <= index;
                wdata_tag_o  <= {1'b1, tag};
                wdata_data_o <= line_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Self-checking bench for cc_line_fill_unit: table-driven bursts, hand-written
// corner sequences and randomized bursts against an address/line model.
module tb_cc_line_fill_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  mem_rdata_i = '0;
    logic         mem_rlast_i = 1'b0;
    logic         mem_rvalid_i = 1'b0;
    logic         mem_rready_i = 1'b0;
    logic         miss_addr_fifo_empty_i = 1'b1;
    logic [31:0]  miss_addr_fifo_rdata_i = '0;
    logic         miss_addr_fifo_rden_o;
    logic         wren_o;
    logic [8:0]   waddr_o;
    logic [17:0]  wdata_tag_o;
    logic [511:0] wdata_data_o;
    logic         fill_err_o;

    cc_line_fill_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_i(mem_rready_i),
        .miss_addr_fifo_empty_i(miss_addr_fifo_empty_i),
        .miss_addr_fifo_rdata_i(miss_addr_fifo_rdata_i),
        .miss_addr_fifo_rden_o(miss_addr_fifo_rden_o),
        .wren_o(wren_o), .waddr_o(waddr_o), .wdata_tag_o(wdata_tag_o),
        .wdata_data_o(wdata_data_o), .fill_err_o(fill_err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] d; bit last; bit b7; } beat_t;
    typedef struct { logic [8:0] idx; logic [17:0] tag; logic [511:0] line; } wr_t;
    typedef struct {
        logic [31:0] addr; logic [63:0] base; int stall;
        logic [8:0] exp_waddr; logic [17:0] exp_tag;
    } vec_t;

    logic [31:0] addr_q[$];
    beat_t       beat_q[$];
    wr_t         exp_q[$];
    int          wr_cyc[$];

    int total = 0, bad = 0;
    int cyc = 0, lastb_cyc = -100, stall = 0;
    int nwr = 0, npop = 0, nhs = 0;
    bit prev_wren = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive FIFO head and R channel from the bench queues.
    task automatic drive();
        miss_addr_fifo_empty_i = (addr_q.size() == 0);
        miss_addr_fifo_rdata_i = (addr_q.size() == 0) ? 32'h0 : addr_q[0];
        mem_rvalid_i = (beat_q.size() > 0) && (int'($urandom_range(99)) >= stall);
        mem_rready_i = (int'($urandom_range(99)) >= stall);
        mem_rdata_i  = mem_rvalid_i ? beat_q[0].d : {$urandom, $urandom};
        mem_rlast_i  = mem_rvalid_i ? beat_q[0].last : 1'b0;
    endtask

    // One clock: observe at negedge, retire pops/beats at posedge, redrive.
    task automatic step();
        bit pop, hs;
        wr_t e;
        @(negedge clk);
        pop = miss_addr_fifo_rden_o && (addr_q.size() > 0);
        hs  = mem_rvalid_i && mem_rready_i;
        if (miss_addr_fifo_rden_o) npop++;
        if (hs && beat_q[0].b7) lastb_cyc = cyc;
        if (wren_o) begin
            nwr++;
            wr_cyc.push_back(cyc);
            chk("wren_width", prev_wren, 0);
            chk("wr_latency", cyc, lastb_cyc + 1);
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("waddr", waddr_o, e.idx);
                chk("wtag", wdata_tag_o, e.tag);
                chk("wdata", wdata_data_o, e.line);
            end
        end
        prev_wren = wren_o;
        @(posedge clk);
        cyc++;
        if (pop) void'(addr_q.pop_front());
        if (hs) begin void'(beat_q.pop_front()); nhs++; end
        #1;
        drive();
    endtask

    // Queue one miss plus its burst, and the write the model predicts.
    task automatic queue_burst(input logic [31:0] a, input logic [63:0] base, input bit rnd,
                               input int rlast_pos, input logic [8:0] widx, input logic [17:0] wtag);
        wr_t e;
        beat_t b;
        int s;
        s = int'((a % 64) / 8);
        e.idx = widx; e.tag = wtag; e.line = '0;
        addr_q.push_back(a);
        for (int k = 0; k < 8; k++) begin
            b.d = rnd ? {$urandom, $urandom} : base + 64'(k);
            b.last = (k == rlast_pos);
            b.b7 = (k == 7);
            beat_q.push_back(b);
            e.line[((s + k) % 8) * 64 +: 64] = b.d;
        end
        exp_q.push_back(e);
    endtask

    task automatic queue_rand(input int rlast_pos);
        logic [31:0] a;
        a = $urandom;
        queue_burst(a, 64'h0, 1, rlast_pos, 9'((a / 64) % 512), {1'b1, 17'(a / 32768)});
    endtask

    task automatic drain();
        int n = 0;
        while ((beat_q.size() > 0 || addr_q.size() > 0 || exp_q.size() > 0) && n < 2000) begin
            step(); n++;
        end
        step(); step();
        chk("drain_timeout", (n < 2000), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        addr_q.delete(); beat_q.delete(); exp_q.delete(); wr_cyc.delete();
        drive();
        prev_wren = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nwr = 0; npop = 0; nhs = 0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0001_2340, 64'h1111_0000_0000_0000, 0,  9'h08D, 18'h20002};
        vecs[1] = '{32'h0001_2368, 64'hB000_0000_0000_0000, 0,  9'h08D, 18'h20002};
        vecs[2] = '{32'h0001_2340, 64'h1111_0000_0000_0000, 30, 9'h08D, 18'h20002};
        vecs[3] = '{32'hFFFF_FFC0, 64'hDEAD_BEEF_0000_0000, 30, 9'h1FF, 18'h3FFFF};
        vecs[4] = '{32'h0000_003F, 64'h0123_4567_89AB_0000, 0,  9'h000, 18'h20000};
        vecs[5] = '{32'h8000_8018, 64'h5555_AAAA_0000_0000, 20, 9'h000, 18'h30001};

        // Reset state.
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rden", miss_addr_fifo_rden_o, 0);
        chk("rst_wren", wren_o, 0);
        chk("rst_waddr", waddr_o, 0);
        chk("rst_tag", wdata_tag_o, 0);
        chk("rst_data", wdata_data_o, 0);
        chk("rst_err", fill_err_o, 0);
        do_reset();

        // Table-driven single bursts.
        for (int i = 0; i < 6; i++) begin
            stall = vecs[i].stall;
            nwr = 0; npop = 0;
            queue_burst(vecs[i].addr, vecs[i].base, 0, 7, vecs[i].exp_waddr, vecs[i].exp_tag);
            drain();
            chk($sformatf("vec%0d_writes", i), nwr, 1);
            chk($sformatf("vec%0d_pops", i), npop, 1);
            chk($sformatf("vec%0d_err", i), fill_err_o, 0);
        end

        // Back-to-back: second beat 0 right after first beat 7.
        stall = 0; nwr = 0; npop = 0; wr_cyc.delete();
        queue_burst(32'h0000_1240, 64'hA0, 0, 7, 9'h049, 18'h20000);
        queue_burst(32'h0004_0A08, 64'hB0, 0, 7, 9'h028, 18'h20008);
        drain();
        chk("b2b_writes", nwr, 2);
        chk("b2b_pops", npop, 2);
        if (wr_cyc.size() == 2) chk("b2b_gap", wr_cyc[1] - wr_cyc[0], 8);
        else chk("b2b_wrcount", wr_cyc.size(), 2);
        chk("b2b_err", fill_err_o, 0);

        // Randomized bursts with stalls, in small back-to-back batches.
        stall = 30; nwr = 0; npop = 0;
        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'($urandom_range(3, 1));
            for (int j = 0; j < n; j++) queue_rand(7);
            drain();
        end
        chk("rand_pops_eq_writes", npop, nwr);
        chk("rand_err", fill_err_o, 0);

        // rlast early on beat 3: error, but still eight beats and one write.
        do_reset();
        stall = 10;
        queue_rand(3);
        drain();
        chk("early_rlast_err", fill_err_o, 1);
        chk("early_rlast_writes", nwr, 1);
        chk("early_rlast_beats", nhs, 8);

        // Missing rlast on beat 7.
        do_reset();
        queue_rand(-1);
        drain();
        chk("no_rlast_err", fill_err_o, 1);
        chk("no_rlast_writes", nwr, 1);

        // Stray beat with the FIFO empty.
        do_reset();
        begin
            beat_t b;
            b.d = 64'hFEED; b.last = 1'b1; b.b7 = 1'b0;
            beat_q.push_back(b);
        end
        drain();
        chk("stray_err", fill_err_o, 1);
        chk("stray_writes", nwr, 0);

        // Reset in the middle of a fill, then a clean fill.
        do_reset();
        stall = 0;
        queue_rand(7);
        begin
            int n = 0;
            while (nhs < 5 && n < 200) begin step(); n++; end
            chk("midfill_reach", nhs, 5);
        end
        rst_n = 1'b0;
        addr_q.delete(); beat_q.delete(); exp_q.delete();
        drive();
        #1;
        chk("abort_rden", miss_addr_fifo_rden_o, 0);
        chk("abort_wren", wren_o, 0);
        chk("abort_waddr", waddr_o, 0);
        chk("abort_tag", wdata_tag_o, 0);
        chk("abort_data", wdata_data_o, 0);
        chk("abort_err", fill_err_o, 0);
        do_reset();
        stall = 20;
        queue_burst(32'h0001_2368, 64'hC0C0_0000_0000_0000, 0, 7, 9'h08D, 18'h20002);
        drain();
        chk("after_abort_writes", nwr, 1);
        chk("after_abort_err", fill_err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_line_fill_unit.md
# cc_line_fill_unit

Miss-fill stage of the cache controller. It pops one miss address per outstanding miss from the miss-address FIFO and observes the memory AXI R channel, which is owned by the reorder unit. It collects the 8-beat WRAP burst returned for that miss, rotates the beats back into line order, and issues one 512-bit line write plus valid tag to the cache SRAM write port. It sits between the memory R channel and the SRAM write port, in parallel with the reorder unit.

## Interface
- Parameters: none. Geometry is fixed:
  - 32-bit address: tag = addr[31:15], index = addr[14:6], offset = addr[5:0].
  - 64 B line, 8 × 64-bit beats, 512 sets.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- mem_rdata_i  in  64  memory read beat.
- mem_rlast_i  in  1  last beat of burst.
- mem_rvalid_i  in  1  beat valid.
- mem_rready_i  in  1  rready as driven by the reorder unit. A beat is accepted when rvalid & rready.
- miss_addr_fifo_empty_i  in  1  miss-address FIFO empty.
- miss_addr_fifo_rdata_i  in  32  FIFO head; first-word-fall-through, valid whenever not empty.
- miss_addr_fifo_rden_o  out  1  pop strobe, one cycle.
- wren_o  out  1  SRAM write enable, one-cycle pulse.
- waddr_o  out  9  SRAM set index.
- wdata_tag_o  out  18  {valid=1, tag[16:0]}.
- wdata_data_o  out  512  line, word w at bits [64w+63:64w].
- fill_err_o  out  1  sticky protocol error flag; cleared only by reset.

## Operation
- FSM states: IDLE, FILL.
- IDLE
  - If !miss_addr_fifo_empty_i: assert miss_addr_fifo_rden_o this cycle, latch tag/index/start word (offset[5:2+1] = offset[5:3]), clear beat count, go to FILL.
  - If a beat is accepted in that same cycle, it is beat 0 and uses the FIFO head directly. The beat count becomes 1.
  - A beat accepted in IDLE with the FIFO empty is discarded and sets fill_err_o.
- FILL
  - Each accepted beat k (k = 0..7) is stored in line word (start + k) mod 8, using 3-bit wrap-around arithmetic. The count then increments.
  - On accepted beat 7:
    - Copy the assembled line into the output write register. Words written by beat 7 take the current beat's data, not stale data.
    - Load waddr_o = index and wdata_tag_o = {1'b1, tag}, and pulse wren_o the next cycle.
    - Return to IDLE.
  - rlast check: rlast on any beat k < 7 sets fill_err_o. The burst still continues to 8 beats; rlast is not used for termination. A missing rlast on beat 7 also sets fill_err_o.
- Gaps in rvalid or rready of any length are allowed. Only handshaken beats count.
- Exactly one FIFO pop per 8-beat burst. No pop occurs while in FILL.
- The output write register is separate from the assembly buffer. A new burst may begin assembling the cycle after the last beat while the previous line is being written.
- mem_rid_i and mem_rresp_i are not consumed. Error responses are written as received.

## Timing
- Reset values:
  - state = IDLE, count = 0, fill_err_o = 0.
  - miss_addr_fifo_rden_o = 0 (combinational; 0 in IDLE with empty FIFO).
  - wren_o = 0, waddr_o = 0, wdata_tag_o = 0, wdata_data_o = 0.
- miss_addr_fifo_rden_o is combinational from state and empty. It is high for exactly one cycle per pop.
- Latency: wren_o is asserted in the cycle after the beat-7 handshake, for exactly 1 cycle. waddr_o, tag and data are stable during that cycle and hold until the next write.
- Back-to-back bursts:
  - The FIFO holds the next address, so IDLE pops it the cycle after beat 7.
  - If that burst's beat 0 arrives in that same cycle, it is captured with no loss.
  - Sustained throughput is 8 beats per 8 cycles plus 0 bubble.
- Asynchronous reset mid-FILL: the partial line is abandoned and no write is issued. The popped address is lost; this is acceptable because the whole controller resets together.

## Test plan
1. Miss addr 0x0001_2340 (tag 0x0002, index 0x08D, word 0). Beats D0..D7 = 0x1111_0000_0000_000k, rlast on 7.
   -> one pop; wren_o pulse 1 cycle after beat 7; waddr_o = 0x08D; wdata_tag_o = 0x20002; word k = D_k.
2. Wrap: addr offset 0x28 (start word 5), beats B0..B7.
   -> words 5,6,7,0,1,2,3,4 = B0..B7; exactly one write.
3. Back-to-back: two addresses queued; burst 2 beat 0 arrives the cycle after burst 1 beat 7.
   -> two wren_o pulses 8 cycles apart; correct indices and lines; fill_err_o = 0.
4. Stalls: random rvalid low and rready low (30%) through the burst.
   -> line identical to the stall-free run; wren_o only after the 8th handshake.
5. Protocol errors:
   - rlast on beat 3 -> fill_err_o = 1, still 8 beats and one write.
   - A beat with the FIFO empty in IDLE -> fill_err_o = 1, no write.
6. Assert rst_n low after beat 4 of a fill, then release and run a new miss.
   -> all outputs return to reset values immediately; no write for the aborted line; the new fill completes normally.
